// File: rtl/roce_stack_pkg.sv
// +-------------------------------------------------------------------------+
// | roce_stack_pkg: shared RoCE stack types, error codes, command layout    |
// | rev 1.0                                                                 |
// +-------------------------------------------------------------------------+
`default_nettype none

package roce_stack_pkg;

   localparam int DMA_PADDR_W  = 64;
   localparam int DMA_BUFLEN_W = 48;

   typedef struct packed {
      logic [DMA_PADDR_W-1:0]  paddr;
      logic [DMA_BUFLEN_W-1:0] buflen;
      logic [3:0]              accessdesc;
   } dma_req_t;

   localparam int ACC_RD_BIT = 0;
   localparam int ACC_WR_BIT = 1;

   localparam logic [1:0] ERR_NONE     = 2'b00;
   localparam logic [1:0] ERR_ACCESS   = 2'b01;
   localparam logic [1:0] ERR_BOUNDS   = 2'b10;
   localparam logic [1:0] ERR_ZERO_LEN = 2'b11;

   // DataMover command field offsets, relative to the top of the BTT field
   localparam int CMD_INCR_OFS = 0;
   localparam int CMD_DSA_OFS  = 1;
   localparam int CMD_DSA_W    = 6;
   localparam int CMD_EOF_OFS  = 7;
   localparam int CMD_DRR_OFS  = 8;
   localparam int CMD_ADDR_OFS = 9;

   function automatic int cmd_width(input int addr_w, input int btt_w, input int tag_w);
      return 4 + tag_w + addr_w + CMD_ADDR_OFS + btt_w;
   endfunction

   typedef enum logic [2:0] {
      ST_IDLE       = 3'd0,
      ST_XLATE_REQ  = 3'd1,
      ST_XLATE_WAIT = 3'd2,
      ST_CHECK      = 3'd3,
      ST_EMIT       = 3'd4,
      ST_ERR        = 3'd5
   } xlate_state_e;

endpackage

`default_nettype wire

// File: rtl/roce_dm_cmd_pack.sv
// +-------------------------------------------------------------------------+
// | roce_dm_cmd_pack: packs tag/addr/eof/btt into a DataMover command word  |
// | rev 1.0                                                                 |
// +-------------------------------------------------------------------------+
`default_nettype none

module roce_dm_cmd_pack
   import roce_stack_pkg::*;
#(
   parameter int ADDR_W = 64,
   parameter int BTT_W  = 23,
   parameter int TAG_W  = 4
) (
   input  logic [TAG_W-1:0]                          tag_i,
   input  logic [ADDR_W-1:0]                         addr_i,
   input  logic                                      eof_i,
   input  logic [BTT_W-1:0]                          btt_i,
   output logic [cmd_width(ADDR_W, BTT_W, TAG_W)-1:0] cmd_o
);

   always_comb begin
      cmd_o                                       = '0;
      cmd_o[BTT_W-1:0]                            = btt_i;
      cmd_o[BTT_W+CMD_INCR_OFS]                   = 1'b1;
      cmd_o[BTT_W+CMD_DSA_OFS +: CMD_DSA_W]       = '0;
      cmd_o[BTT_W+CMD_EOF_OFS]                    = eof_i;
      cmd_o[BTT_W+CMD_DRR_OFS]                    = 1'b0;
      cmd_o[BTT_W+CMD_ADDR_OFS +: ADDR_W]         = addr_i;
      cmd_o[BTT_W+CMD_ADDR_OFS+ADDR_W +: TAG_W]   = tag_i;
   end

endmodule

`default_nettype wire

// File: rtl/roce_req_xlate_splitter.sv
// +-------------------------------------------------------------------------+
// | roce_req_xlate_splitter: per-message vaddr translation, rights/bounds   |
// | check and MAX_BTT splitting of request segments into DataMover commands |
// | rev 1.0                                                                 |
// +-------------------------------------------------------------------------+
`default_nettype none

module roce_req_xlate_splitter
   import roce_stack_pkg::*;
#(
   parameter bit READ    = 1'b1,
   parameter int ADDR_W  = 64,
   parameter int LEN_W   = 28,
   parameter int BTT_W   = 23,
   parameter int TAG_W   = 4,
   parameter int MAX_BTT = 2**22
) (
   input  logic                                      clk_i,
   input  logic                                      aresetn_i,
   input  logic                                      s_req_valid_i,
   output logic                                      s_req_ready_o,
   input  logic [ADDR_W-1:0]                         s_req_vaddr_i,
   input  logic [LEN_W-1:0]                          s_req_len_i,
   input  logic                                      s_req_last_i,
   output logic                                      req_addr_valid_o,
   input  logic                                      req_addr_ready_i,
   output logic [ADDR_W-1:0]                         req_addr_vaddr_o,
   input  logic                                      resp_addr_valid_i,
   output logic                                      resp_addr_ready_o,
   input  dma_req_t                                  resp_addr_data_i,
   output logic                                      cmd_valid_o,
   input  logic                                      cmd_ready_i,
   output logic [cmd_width(ADDR_W, BTT_W, TAG_W)-1:0] cmd_data_o,
   output logic                                      err_valid_o,
   output logic [1:0]                                err_code_o
);

   localparam int               CMD_W       = cmd_width(ADDR_W, BTT_W, TAG_W);
   localparam int               ACC_BIT     = READ ? ACC_RD_BIT : ACC_WR_BIT;
   localparam logic [LEN_W-1:0] C_MAX_CHUNK = LEN_W'(MAX_BTT);

   xlate_state_e              r_state, w_state_nxt;
   logic [ADDR_W-1:0]         r_vaddr, r_base, r_paddr, r_cur_addr;
   logic [LEN_W-1:0]          r_len, r_remaining;
   logic [DMA_BUFLEN_W-1:0]   r_buflen;
   logic                      r_acc_ok, r_last, r_first, r_drain;
   logic [TAG_W-1:0]          r_tag;
   logic [1:0]                r_err_code;

   logic [ADDR_W-1:0]         w_offset;
   logic [ADDR_W:0]           w_span;
   logic [1:0]                w_err_code;
   logic [LEN_W-1:0]          w_chunk;
   logic                      w_final;
   logic [CMD_W-1:0]          w_cmd;
   logic                      w_unused;

   assign w_unused   = ^resp_addr_data_i.accessdesc;
   assign err_code_o = r_err_code;

   // Offset and span are taken at full address width so the bounds compare cannot wrap
   assign w_offset = r_vaddr - r_base;
   assign w_span   = {1'b0, w_offset} + (ADDR_W+1)'(r_len);
   assign w_final  = (r_remaining <= C_MAX_CHUNK);
   assign w_chunk  = w_final ? r_remaining : C_MAX_CHUNK;

   always_comb begin
      w_err_code = ERR_NONE;
      if (r_len == '0)
         w_err_code = ERR_ZERO_LEN;
      else if (!r_acc_ok)
         w_err_code = ERR_ACCESS;
      else if (w_span > (ADDR_W+1)'(r_buflen))
         w_err_code = ERR_BOUNDS;
   end

   roce_dm_cmd_pack #(
      .ADDR_W (ADDR_W),
      .BTT_W  (BTT_W),
      .TAG_W  (TAG_W)
   ) u_pack (
      .tag_i  (r_tag),
      .addr_i (r_cur_addr),
      .eof_i  (w_final & r_last),
      .btt_i  (BTT_W'(w_chunk)),
      .cmd_o  (w_cmd)
   );

   always_ff @(posedge clk_i or negedge aresetn_i) begin
      if (!aresetn_i)
         r_state <= ST_IDLE;
      else
         r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt       = r_state;
      s_req_ready_o     = 1'b0;
      req_addr_valid_o  = 1'b0;
      req_addr_vaddr_o  = '0;
      resp_addr_ready_o = 1'b0;
      cmd_valid_o       = 1'b0;
      cmd_data_o        = '0;
      err_valid_o       = 1'b0;
      case (r_state)
         ST_IDLE: begin
            s_req_ready_o = 1'b1;
            if (s_req_valid_i && !r_drain)
               w_state_nxt = r_first ? ST_XLATE_REQ : ST_CHECK;
         end
         ST_XLATE_REQ: begin
            req_addr_valid_o = 1'b1;
            req_addr_vaddr_o = r_base;
            if (req_addr_ready_i)
               w_state_nxt = ST_XLATE_WAIT;
         end
         ST_XLATE_WAIT: begin
            resp_addr_ready_o = 1'b1;
            if (resp_addr_valid_i)
               w_state_nxt = ST_CHECK;
         end
         ST_CHECK:
            w_state_nxt = (w_err_code != ERR_NONE) ? ST_ERR : ST_EMIT;
         ST_EMIT: begin
            cmd_valid_o = 1'b1;
            cmd_data_o  = w_cmd;
            if (cmd_ready_i && w_final)
               w_state_nxt = ST_IDLE;
         end
         ST_ERR: begin
            err_valid_o = 1'b1;
            w_state_nxt = ST_IDLE;
         end
         default:
            w_state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk_i or negedge aresetn_i) begin
      if (!aresetn_i) begin
         r_vaddr     <= '0;
         r_base      <= '0;
         r_paddr     <= '0;
         r_cur_addr  <= '0;
         r_len       <= '0;
         r_remaining <= '0;
         r_buflen    <= '0;
         r_acc_ok    <= 1'b0;
         r_last      <= 1'b0;
         r_first     <= 1'b1;
         r_drain     <= 1'b0;
         r_tag       <= '0;
         r_err_code  <= ERR_NONE;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (s_req_valid_i) begin
                  if (r_drain) begin
                     if (s_req_last_i) begin
                        r_drain <= 1'b0;
                        r_first <= 1'b1;
                     end
                  end else begin
                     r_vaddr <= s_req_vaddr_i;
                     r_len   <= s_req_len_i;
                     r_last  <= s_req_last_i;
                     if (r_first) begin
                        r_base  <= s_req_vaddr_i;
                        r_first <= 1'b0;
                     end
                  end
               end
            end
            ST_XLATE_WAIT: begin
               if (resp_addr_valid_i) begin
                  r_paddr  <= resp_addr_data_i.paddr[ADDR_W-1:0];
                  r_buflen <= resp_addr_data_i.buflen;
                  r_acc_ok <= resp_addr_data_i.accessdesc[ACC_BIT];
               end
            end
            ST_CHECK: begin
               if (w_err_code != ERR_NONE) begin
                  r_err_code <= w_err_code;
               end else begin
                  r_cur_addr  <= r_paddr + w_offset;
                  r_remaining <= r_len;
               end
            end
            ST_EMIT: begin
               if (cmd_ready_i) begin
                  r_cur_addr  <= r_cur_addr + ADDR_W'(w_chunk);
                  r_remaining <= r_remaining - w_chunk;
                  r_tag       <= r_tag + TAG_W'(1);
                  if (w_final)
                     r_first <= r_last;
               end
            end
            ST_ERR: begin
               if (r_last)
                  r_first <= 1'b1;
               else
                  r_drain <= 1'b1;
            end
            default: ;
         endcase
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_roce_req_xlate_splitter.sv
// +-------------------------------------------------------------------------+
// | tb_roce_req_xlate_splitter: directed self-checking bench                |
// | rev 1.0                                                                 |
// +-------------------------------------------------------------------------+
`default_nettype none

module tb_roce_req_xlate_splitter;
   import roce_stack_pkg::*;

   logic          clk_i = 1'b0;
   logic          aresetn_i;
   logic          s_req_valid_i;
   logic          s_req_ready_o;
   logic [63:0]   s_req_vaddr_i;
   logic [27:0]   s_req_len_i;
   logic          s_req_last_i;
   logic          req_addr_valid_o;
   logic          req_addr_ready_i;
   logic [63:0]   req_addr_vaddr_o;
   logic          resp_addr_valid_i;
   logic          resp_addr_ready_o;
   dma_req_t      resp_addr_data_i;
   logic          cmd_valid_o;
   logic          cmd_ready_i;
   logic [103:0]  cmd_data_o;
   logic          err_valid_o;
   logic [1:0]    err_code_o;

   int            n_checks = 0;
   int            n_errors = 0;
   int            cyc = 0;
   int            xlate_cnt = 0;
   int            err_cnt = 0;
   logic [63:0]   xlate_va = '0;
   logic [1:0]    err_last = '0;
   logic [103:0]  q_cmd[$];
   int            q_cyc[$];

   roce_req_xlate_splitter #(
      .READ    (1'b1),
      .MAX_BTT (32'h1000)
   ) dut (
      .clk_i             (clk_i),
      .aresetn_i         (aresetn_i),
      .s_req_valid_i     (s_req_valid_i),
      .s_req_ready_o     (s_req_ready_o),
      .s_req_vaddr_i     (s_req_vaddr_i),
      .s_req_len_i       (s_req_len_i),
      .s_req_last_i      (s_req_last_i),
      .req_addr_valid_o  (req_addr_valid_o),
      .req_addr_ready_i  (req_addr_ready_i),
      .req_addr_vaddr_o  (req_addr_vaddr_o),
      .resp_addr_valid_i (resp_addr_valid_i),
      .resp_addr_ready_o (resp_addr_ready_o),
      .resp_addr_data_i  (resp_addr_data_i),
      .cmd_valid_o       (cmd_valid_o),
      .cmd_ready_i       (cmd_ready_i),
      .cmd_data_o        (cmd_data_o),
      .err_valid_o       (err_valid_o),
      .err_code_o        (err_code_o)
   );

   always #5 clk_i = ~clk_i;

   always @(posedge clk_i) cyc <= cyc + 1;

   always @(negedge clk_i) begin
      if (cmd_valid_o && cmd_ready_i) begin
         q_cmd.push_back(cmd_data_o);
         q_cyc.push_back(cyc);
      end
      if (req_addr_valid_o && req_addr_ready_i) begin
         xlate_cnt <= xlate_cnt + 1;
         xlate_va  <= req_addr_vaddr_o;
      end
      if (err_valid_o) begin
         err_cnt  <= err_cnt + 1;
         err_last <= err_code_o;
      end
   end

   task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s got %h expected %h", tag, got, exp);
      end
   endtask

   function automatic logic [103:0] exp_cmd(input logic [3:0] tag, input logic [63:0] addr,
                                            input logic eof, input logic [22:0] btt);
      return {4'b0, tag, addr, 1'b0, eof, 6'b0, 1'b1, btt};
   endfunction

   task automatic set_resp(input logic [63:0] pa, input logic [47:0] bl, input logic [3:0] ad);
      resp_addr_data_i.paddr      = pa;
      resp_addr_data_i.buflen     = bl;
      resp_addr_data_i.accessdesc = ad;
   endtask

   task automatic step(input int n);
      repeat (n) @(posedge clk_i);
      #1;
   endtask

   task automatic send(input logic [63:0] va, input logic [27:0] ln, input logic lst,
                       output int acc_cyc);
      bit done = 1'b0;
      acc_cyc       = -1;
      s_req_vaddr_i = va;
      s_req_len_i   = ln;
      s_req_last_i  = lst;
      s_req_valid_i = 1'b1;
      for (int i = 0; i < 60 && !done; i++) begin
         @(negedge clk_i);
         if (s_req_ready_o) begin
            done    = 1'b1;
            acc_cyc = cyc;
         end
         @(posedge clk_i);
         #1;
      end
      s_req_valid_i = 1'b0;
      if (!done) chk("send_timeout", 0, 1);
   endtask

   task automatic wait_cmd_valid(input string tag);
      bit seen = 1'b0;
      for (int i = 0; i < 20 && !seen; i++) begin
         @(negedge clk_i);
         seen = cmd_valid_o;
      end
      chk(tag, seen, 1);
   endtask

   initial begin
      int a0, a1, n0, x0, e0;
      aresetn_i         = 1'b0;
      s_req_valid_i     = 1'b0;
      s_req_vaddr_i     = '0;
      s_req_len_i       = '0;
      s_req_last_i      = 1'b0;
      req_addr_ready_i  = 1'b1;
      resp_addr_valid_i = 1'b1;
      cmd_ready_i       = 1'b1;
      set_resp(64'h8000_0000, 48'h1000, 4'h1);
      step(3);
      chk("rst_s_ready", s_req_ready_o, 1);
      chk("rst_valids", {req_addr_valid_o, resp_addr_ready_o, cmd_valid_o, err_valid_o}, 0);
      chk("rst_err_code", err_code_o, 0);
      chk("rst_cmd_data", cmd_data_o, 0);
      chk("rst_req_vaddr", req_addr_vaddr_o, 0);
      aresetn_i = 1'b1;
      step(2);

      // single-segment message
      n0 = q_cmd.size(); x0 = xlate_cnt;
      send(64'h1000, 28'h100, 1'b1, a0);
      step(10);
      chk("t1_ncmd", q_cmd.size() - n0, 1);
      chk("t1_cmd", q_cmd[n0], exp_cmd(4'd0, 64'h8000_0000, 1'b1, 23'h100));
      chk("t1_latency", q_cyc[n0] - a0, 4);
      chk("t1_nxlate", xlate_cnt - x0, 1);
      chk("t1_xlate_va", xlate_va, 64'h1000);

      // two-segment message reuses the cached translation
      n0 = q_cmd.size(); x0 = xlate_cnt;
      send(64'h1000, 28'h100, 1'b0, a0);
      send(64'h1400, 28'h80, 1'b1, a1);
      step(10);
      chk("t2_ncmd", q_cmd.size() - n0, 2);
      chk("t2_cmd0", q_cmd[n0], exp_cmd(4'd1, 64'h8000_0000, 1'b0, 23'h100));
      chk("t2_cmd1", q_cmd[n0+1], exp_cmd(4'd2, 64'h8000_0400, 1'b1, 23'h80));
      chk("t2_mid_latency", q_cyc[n0+1] - a1, 2);
      chk("t2_nxlate", xlate_cnt - x0, 1);

      // backpressure: command word held steady
      n0 = q_cmd.size();
      cmd_ready_i = 1'b0;
      send(64'h1000, 28'h40, 1'b1, a0);
      wait_cmd_valid("stall_valid");
      for (int i = 0; i < 5; i++) begin
         @(negedge clk_i);
         chk("stall_cmd", {cmd_valid_o, cmd_data_o}, {1'b1, exp_cmd(4'd3, 64'h8000_0000, 1'b1, 23'h40)});
      end
      @(posedge clk_i); #1;
      cmd_ready_i = 1'b1;
      step(4);
      chk("stall_ncmd", q_cmd.size() - n0, 1);

      // access denied on a non-last segment, rest of message drained
      n0 = q_cmd.size(); x0 = xlate_cnt; e0 = err_cnt;
      set_resp(64'h8000_0000, 48'h1000, 4'h2);
      send(64'h1000, 28'h100, 1'b0, a0);
      send(64'h1100, 28'h100, 1'b0, a0);
      send(64'h1200, 28'h100, 1'b1, a0);
      step(6);
      chk("acc_nerr", err_cnt - e0, 1);
      chk("acc_code", err_last, ERR_ACCESS);
      chk("acc_ncmd", q_cmd.size() - n0, 0);
      set_resp(64'h8000_0000, 48'h1000, 4'h1);
      send(64'h1000, 28'h20, 1'b1, a0);
      step(8);
      chk("acc_retranslate", xlate_cnt - x0, 2);
      chk("acc_next_cmd", q_cmd[n0], exp_cmd(4'd4, 64'h8000_0000, 1'b1, 23'h20));
      chk("acc_code_held", err_code_o, ERR_ACCESS);

      // bounds: exact fit passes, one byte over fails
      n0 = q_cmd.size(); e0 = err_cnt;
      send(64'h1000, 28'h1000, 1'b1, a0);
      send(64'h1000, 28'h800, 1'b0, a0);
      send(64'h1800, 28'h801, 1'b1, a0);
      step(6);
      chk("bnd_ncmd", q_cmd.size() - n0, 2);
      chk("bnd_fit_cmd", q_cmd[n0], exp_cmd(4'd5, 64'h8000_0000, 1'b1, 23'h1000));
      chk("bnd_seg_cmd", q_cmd[n0+1], exp_cmd(4'd6, 64'h8000_0000, 1'b0, 23'h800));
      chk("bnd_nerr", err_cnt - e0, 1);
      chk("bnd_code", err_last, ERR_BOUNDS);

      // zero length outranks missing rights
      n0 = q_cmd.size(); e0 = err_cnt;
      set_resp(64'h8000_0000, 48'h1000, 4'h0);
      send(64'h1000, 28'h0, 1'b1, a0);
      step(6);
      chk("zero_code", err_last, ERR_ZERO_LEN);
      chk("zero_nerr", err_cnt - e0, 1);
      chk("zero_ncmd", q_cmd.size() - n0, 0);

      // async reset while a command is pending
      set_resp(64'h8000_0000, 48'h1000, 4'h1);
      cmd_ready_i = 1'b0;
      send(64'h1000, 28'h40, 1'b1, a0);
      wait_cmd_valid("mid_emit_valid");
      @(posedge clk_i); #1;
      aresetn_i = 1'b0;
      #1;
      chk("mid_rst_cmd", {cmd_valid_o, cmd_data_o}, 0);
      chk("mid_rst_outs", {s_req_ready_o, req_addr_valid_o, resp_addr_ready_o, err_valid_o, err_code_o}, 6'b100000);
      @(posedge clk_i); #1;
      aresetn_i   = 1'b1;
      cmd_ready_i = 1'b1;
      step(2);

      // split into MAX_BTT chunks, first message after reset re-translates
      n0 = q_cmd.size(); x0 = xlate_cnt;
      set_resp(64'h9000_0000, 48'h1_0000, 4'h1);
      send(64'h5000, 28'h2800, 1'b1, a0);
      step(12);
      chk("split_ncmd", q_cmd.size() - n0, 3);
      chk("split_cmd0", q_cmd[n0],   exp_cmd(4'd0, 64'h9000_0000, 1'b0, 23'h1000));
      chk("split_cmd1", q_cmd[n0+1], exp_cmd(4'd1, 64'h9000_1000, 1'b0, 23'h1000));
      chk("split_cmd2", q_cmd[n0+2], exp_cmd(4'd2, 64'h9000_2000, 1'b1, 23'h800));
      chk("split_rate", q_cyc[n0+2] - q_cyc[n0], 2);
      chk("split_nxlate", xlate_cnt - x0, 1);
      chk("split_xlate_va", xlate_va, 64'h5000);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/roce_req_xlate_splitter.md
# roce_req_xlate_splitter

Parametrised successor to the RoCE request handler. It accepts RDMA read or write request segments and translates each message's base virtual address once through the address-lookup service. It checks access rights and buffer bounds, then splits every segment into one or more AXI DataMover commands of at most `MAX_BTT` bytes. It sits between the RoCE stack request stream and the DataMover MM2S (`READ=1`) or S2MM (`READ=0`) command port.

## Interface
- `READ`, 1'b1: direction; selects which accessdesc permission bit is required (bit0 = read, bit1 = write).
- `ADDR_W`, 64: virtual and physical address width.
- `LEN_W`, 28: request length width.
- `BTT_W`, 23: DataMover BTT field width.
- `TAG_W`, 4: command tag width.
- `MAX_BTT`, 2**22: maximum bytes per emitted command; must be ≥1 and < 2**BTT_W.
- `clk_i`  in  1  clock.
- `aresetn_i`  in  1  reset; asynchronous, active-low.
- `s_req_valid_i` / `s_req_ready_o`  in/out  1  request segment handshake.
- `s_req_vaddr_i`  in  ADDR_W  segment virtual address.
- `s_req_len_i`  in  LEN_W  segment length in bytes.
- `s_req_last_i`  in  1  last segment of the message.
- `req_addr_valid_o` / `req_addr_ready_i`  out/in  1  translate-request handshake.
- `req_addr_vaddr_o`  out  ADDR_W  base vaddr to translate.
- `resp_addr_valid_i` / `resp_addr_ready_o`  in/out  1  translate-response handshake.
- `resp_addr_data_i`  in  dma_req_t  {paddr, buflen[47:0], accessdesc[3:0]}.
- `cmd_valid_o` / `cmd_ready_i`  out/in  1  DataMover command handshake.
- `cmd_data_o`  out  8+ADDR_W+9+BTT_W  {4'b0, tag, paddr, DRR=0, EOF, DSA=6'b0, INCR=1, btt}; 104 bits at defaults.
- `err_valid_o`  out  1  one-cycle error pulse.
- `err_code_o`  out  2  01 access denied, 10 out of bounds, 11 zero length; held until the next error.

## Operation
- States: IDLE, XLATE_REQ, XLATE_WAIT, CHECK, EMIT, ERR.
- IDLE:
  - `s_req_ready_o`=1; on accept, latch vaddr, len and last.
  - If `first_q` (start of message): base_vaddr ← vaddr, go XLATE_REQ. Otherwise go CHECK.
  - If `drain_q`: accept and drop the segment; clear `drain_q` and set `first_q` when last=1; stay in IDLE.
- XLATE_REQ: `req_addr_valid_o`=1, vaddr = base_vaddr; go XLATE_WAIT on ready.
- XLATE_WAIT: `resp_addr_ready_o`=1; on valid, latch paddr, buflen and accessdesc; go CHECK.
- CHECK (one cycle):
  - offset = vaddr − base_vaddr, computed at ADDR_W.
  - Error priority, first match wins: len==0 → code 11; required accessdesc bit clear → 01; offset+len > buflen (ADDR_W+1-bit compare, buflen zero-extended) → 10.
  - No error: cur_addr = paddr+offset, remaining = len, go EMIT.
- EMIT:
  - `cmd_valid_o`=1 with btt = min(remaining, MAX_BTT), addr = cur_addr, tag = tag_q.
  - EOF=1 only on the final chunk of a segment with last=1.
  - On ready: cur_addr += btt, remaining −= btt, tag_q++ (wraps mod 2**TAG_W).
  - When remaining hits 0: `first_q` ← last; go IDLE.
- ERR:
  - `err_valid_o`=1 for one cycle, `err_code_o` updated; nothing is emitted.
  - If the errored segment had last=0, set `drain_q`; else set `first_q`. Go IDLE.
- Translation is cached per message; middle segments never re-translate.

## Timing
- Reset values:
  - State IDLE; `first_q`=1, `drain_q`=0, tag 0.
  - Outputs: `s_req_ready_o`=1; all other valids 0; `err_code_o`=0; `cmd_data_o`=0; `req_addr_vaddr_o`=0.
- Minimum latency from accept to first `cmd_valid_o`:
  - First segment: 4 cycles (XLATE_REQ, XLATE_WAIT, CHECK, EMIT), with single-cycle ready/valid responses.
  - Middle segment: 2 cycles.
- Chunk throughput: one command per cycle while `cmd_ready_i`=1.
- `cmd_valid_o` and `cmd_data_o` stay stable until ready. `req_addr_valid_o` and `req_addr_vaddr_o` likewise.
- `resp_addr_valid_i` outside XLATE_WAIT is not acknowledged.
- Async reset mid-EMIT drops the command immediately; the message restarts with the next segment treated as first.

## Structure
- Shared package `roce_stack_pkg`: `dma_req_t`, accessdesc bit positions, error-code localparams, DataMover command field offsets.
- Optional sub-module `roce_dm_cmd_pack`: combinational packer of {tag, addr, eof, btt} into the command word. All sequencing stays in the top module.

## Test plan
- First segment vaddr=0x1000, len=0x100, last=1; lookup returns paddr=0x8000_0000, buflen=0x1000, accessdesc=0x1 → one cmd: addr 0x8000_0000, btt 0x100, EOF=1, tag 0.
- Two-segment message, second segment vaddr=0x1400, len=0x80 → second cmd addr 0x8000_0400, EOF=1; exactly one translate request observed.
- `MAX_BTT`=0x1000, len=0x2800, last=1 → three cmds: btt 0x1000/0x1000/0x800; addrs +0x1000 each; tags 0,1,2; EOF only on the third.
- `READ`=0 with accessdesc=0x1 → `err_valid_o` pulse, code 01, no cmd. With segment last=0, subsequent segments are dropped through the one with last=1; the next message re-translates.
- offset+len = buflen+1 → code 10; len=0 → code 11. `cmd_ready_i` held low 5 cycles → `cmd_data_o` stable throughout. Reset asserted mid-EMIT → all outputs return to reset values.
